// File: rtl/stream_mux_nx1.sv
// stream_mux_nx1: N-input stream multiplexer with a one-deep registered output.
// MODE=0 forwards the externally selected channel. MODE=1 arbitrates round-robin
// across all valid channels. An out-of-range select never loads anything; it is
// reported on sel_err instead.
//
// Handshake: a beat moves across a channel on a rising clk edge when valid and
// ready are both high on that channel. Valid must not depend on ready. A source
// holds its data stable while valid && !ready. Every in_ready is combinational:
// it may go high while the matching in_valid is low. It is never high when the
// output register is full and stalled.
module stream_mux_nx1 #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int MODE   = 0,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        grant,
  output logic                    sel_err
);

  logic             can_load;
  logic             sel_ok;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] rr_win;
  logic             rr_found;
  logic [SEL_W-1:0] win;
  logic             win_ok;
  logic [WIDTH-1:0] win_data;
  logic             xfer;

  // The output register can take a new beat when it is empty or is draining on this edge.
  assign can_load = !out_valid || out_ready;
  assign sel_ok   = (int'(sel) < NUM_IN);

  // Round-robin scan: the first valid channel after the last granted one, with wraparound.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    rr_idx   = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      rr_idx = SEL_W'((int'(last) + k) % NUM_IN);
      if (!rr_found && in_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx;
      end
    end
  end

  assign win    = (MODE == 1) ? rr_win : sel;
  assign win_ok = (MODE == 1) ? rr_found : sel_ok;

  // At most one channel sees ready: the chosen one, and only if the output can load.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = can_load && win_ok && (win == SEL_W'(i));
    end
  end

  // Data mux written as a one-hot loop, so an illegal select yields zeros rather than X.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (win == SEL_W'(i)) begin
        win_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = |(in_ready & in_valid);

  // Output register, grant, round-robin pointer and select-error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant     <= '0;
      sel_err   <= 1'b0;
      last      <= SEL_W'(NUM_IN - 1);
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        grant     <= win;
        if (MODE == 1) begin
          last <= win;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      sel_err <= (MODE == 0) ? !sel_ok : 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Bench for stream_mux_nx1. One stimulus stream drives two instances:
// u_ext (external select, 3 channels) and u_rr (round-robin, 4 channels).
// A transaction-level model predicts ready, loads and outputs. Predicted beats
// are pushed onto per-instance queues. A monitor pops a beat on every output handshake.
module tb_stream_mux_nx1;
  localparam int W  = 32;
  localparam int SW = 2;
  localparam int EW = SW + W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4*W-1:0] d_data;
  logic [3:0]     d_valid;
  logic [SW-1:0]  d_sel;
  logic           d_ordy;

  logic [2:0]    e_in_ready;
  logic [W-1:0]  e_out_data;
  logic          e_out_valid;
  logic [SW-1:0] e_grant;
  logic          e_sel_err;

  logic [3:0]    r_in_ready;
  logic [W-1:0]  r_out_data;
  logic          r_out_valid;
  logic [SW-1:0] r_grant;
  logic          r_sel_err;

  stream_mux_nx1 #(.WIDTH(W), .NUM_IN(3), .MODE(0)) u_ext (
    .clk(clk), .rst_n(rst_n), .in_data(d_data[3*W-1:0]), .in_valid(d_valid[2:0]),
    .in_ready(e_in_ready), .sel(d_sel), .out_data(e_out_data), .out_valid(e_out_valid),
    .out_ready(d_ordy), .grant(e_grant), .sel_err(e_sel_err)
  );

  stream_mux_nx1 #(.WIDTH(W), .NUM_IN(4), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(d_data), .in_valid(d_valid),
    .in_ready(r_in_ready), .sel(d_sel), .out_data(r_out_data), .out_valid(r_out_valid),
    .out_ready(d_ordy), .grant(r_grant), .sel_err(r_sel_err)
  );

  // scoreboard state
  logic [EW-1:0] exp_q_ext[$];
  logic [EW-1:0] exp_q_rr[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model state, index 0 = u_ext, 1 = u_rr
  int            n_of[2]    = '{3, 4};
  int            mode_of[2] = '{0, 1};
  bit            m_full[2];
  logic [W-1:0]  m_data[2];
  int            m_grant[2];
  int            m_last[2];
  bit            m_err[2];
  bit            p_xfer[2];
  int            p_win[2];
  logic [W-1:0]  p_data[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict and check ready, step the model, check registered outputs.
  task automatic step(input bit rst, input logic [SW-1:0] s, input logic [3:0] v, input bit ordy);
    bit         can;
    bit         legal;
    int         win;
    int         idx;
    logic [3:0] exp_rdy;
    logic [3:0] act_rdy;
    rst_n   = !rst;
    d_sel   = s;
    d_valid = v;
    d_ordy  = ordy;
    #1;
    for (int d = 0; d < 2; d++) begin
      can   = !m_full[d] || ordy;
      legal = 1'b0;
      win   = 0;
      if (mode_of[d] == 0) begin
        win   = int'(s);
        legal = (win < n_of[d]);
      end else begin
        for (int k = 1; k <= n_of[d]; k++) begin
          idx = (m_last[d] + k) % n_of[d];
          if (!legal && v[idx]) begin
            legal = 1'b1;
            win   = idx;
          end
        end
      end
      exp_rdy = (can && legal) ? 4'(1 << win) : 4'b0000;
      act_rdy = (d == 0) ? {1'b0, e_in_ready} : r_in_ready;
      if (!rst) check((d == 0) ? "ext_in_ready" : "rr_in_ready", 64'(act_rdy), 64'(exp_rdy));
      p_xfer[d] = !rst && can && legal && v[win];
      p_win[d]  = win;
      p_data[d] = d_data[win*W +: W];
      if (p_xfer[d]) begin
        if (d == 0) exp_q_ext.push_back({SW'(win), p_data[d]});
        else        exp_q_rr.push_back({SW'(win), p_data[d]});
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_full[d]  = 1'b0;
        m_data[d]  = '0;
        m_grant[d] = 0;
        m_err[d]   = 1'b0;
        m_last[d]  = n_of[d] - 1;
      end else begin
        if (p_xfer[d]) begin
          m_full[d]  = 1'b1;
          m_data[d]  = p_data[d];
          m_grant[d] = p_win[d];
          if (mode_of[d] == 1) m_last[d] = p_win[d];
        end else if (m_full[d] && ordy) begin
          m_full[d] = 1'b0;
        end
        m_err[d] = (mode_of[d] == 0) && (int'(s) >= n_of[d]);
      end
    end
    if (rst) begin
      exp_q_ext.delete();
      exp_q_rr.delete();
    end
    check("ext_out_valid", 64'(e_out_valid), 64'(m_full[0]));
    check("ext_out_data",  64'(e_out_data),  64'(m_data[0]));
    check("ext_grant",     64'(e_grant),     64'(m_grant[0]));
    check("ext_sel_err",   64'(e_sel_err),   64'(m_err[0]));
    check("rr_out_valid",  64'(r_out_valid), 64'(m_full[1]));
    check("rr_out_data",   64'(r_out_data),  64'(m_data[1]));
    check("rr_grant",      64'(r_grant),     64'(m_grant[1]));
    check("rr_sel_err",    64'(r_sel_err),   64'(m_err[1]));
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) d_data[i*W +: W] = $urandom;
  endtask

  // monitor: every output handshake retires the oldest predicted beat
  always @(negedge clk) begin
    if (rst_n === 1'b1 && d_ordy === 1'b1) begin
      if (e_out_valid === 1'b1) begin
        if (exp_q_ext.size() == 0) check("ext_beat_unexpected", 64'(e_out_data), 64'hDEAD_0000);
        else check("ext_beat", 64'({e_grant, e_out_data}), 64'(exp_q_ext.pop_front()));
      end
      if (r_out_valid === 1'b1) begin
        if (exp_q_rr.size() == 0) check("rr_beat_unexpected", 64'(r_out_data), 64'hDEAD_0000);
        else check("rr_beat", 64'({r_grant, r_out_data}), 64'(exp_q_rr.pop_front()));
      end
    end
  end

  // stimulus
  initial begin
    d_data  = '0;
    d_valid = '0;
    d_sel   = '0;
    d_ordy  = 1'b0;

    // reset held two cycles with channel 2 offering a beat, then released
    d_data[2*W +: W] = 32'hDEAD_BEEF;
    step(1, 2, 4'b0100, 1);
    step(1, 2, 4'b0100, 1);
    step(0, 2, 4'b0100, 1);

    // backpressure on channel 1, then release with no bubble
    d_data[1*W +: W] = 32'h0000_1111;
    step(0, 1, 4'b0010, 1);
    d_data[1*W +: W] = 32'h0000_2222;
    for (int i = 0; i < 3; i++) step(0, 1, 4'b0010, 0);
    step(0, 1, 4'b0010, 1);
    step(0, 1, 4'b0000, 1);

    // round-robin from a fresh pointer: all valid, then only channels 1 and 3
    step(1, 0, 4'b0000, 1);
    for (int i = 0; i < 8; i++) begin
      rand_data();
      step(0, 2'($urandom_range(0, 2)), 4'b1111, 1);
    end
    for (int i = 0; i < 4; i++) begin
      rand_data();
      step(0, 1, 4'b1010, 1);
    end

    // pointer hold under stall: grant lands on 1, stall, then the next grant is 2
    step(1, 0, 4'b0000, 1);
    step(0, 0, 4'b0001, 1);
    rand_data();
    step(0, 1, 4'b0010, 1);
    step(0, 1, 4'b1111, 0);
    step(0, 1, 4'b1111, 0);
    step(0, 1, 4'b1111, 1);

    // illegal select on the 3-channel instance, then recovery on channel 0
    for (int i = 0; i < 3; i++) step(0, 3, 4'b0111, 1);
    rand_data();
    step(0, 0, 4'b0111, 1);
    step(0, 0, 4'b0111, 1);

    // reset while stalled with a full output register, then first grant after reset
    step(0, 1, 4'b0010, 0);
    step(0, 1, 4'b0010, 0);
    step(1, 1, 4'b0010, 0);
    rand_data();
    step(0, 0, 4'b1111, 1);
    step(0, 0, 4'b0000, 1);

    // randomized traffic, including occasional resets and illegal selects
    for (int i = 0; i < 600; i++) begin
      rand_data();
      step(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    // drain and confirm every predicted beat was delivered
    step(0, 0, 4'b0000, 1);
    step(0, 0, 4'b0000, 1);
    step(0, 0, 4'b0000, 1);
    check("ext_queue_left", 64'(exp_q_ext.size()), 64'd0);
    check("rr_queue_left",  64'(exp_q_rr.size()),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_mux_nx1.md
Name: stream_mux_nx1

Overview:
- Parametrised N-input, WIDTH-bit stream multiplexer with a registered output and valid/ready handshakes on every channel.
- Successor to the combinational 4x1 datapath mux, for multicycle datapath sources that may stall, such as the memory-return, ALU-result and register-read paths.
- Two modes:
  - MODE=0: externally selected channel, as in the old mux.
  - MODE=1: internal round-robin arbitration across all valid channels.
- An out-of-range select is flagged, never passed through as X.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_IN, 4, number of input channels, range 2..16.
- MODE, 0, 0 = external select, 1 = round-robin arbitration.
- SEL_W, $clog2(NUM_IN), select/grant width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  NUM_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready, combinational.
- sel  input  SEL_W  channel select; used only when MODE=0, ignored when MODE=1.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- grant  output  SEL_W  registered index of the channel whose beat is in out_data.
- sel_err  output  1  registered; 1 when sel was out of range in the previous cycle (MODE=0 only).

Behaviour:
- Reset: on a clk edge with rst_n=0, all of the following are cleared; this takes precedence over any handshake in the same cycle, and a beat held in the output register is discarded:
  - out_valid=0, out_data=0, grant=0, sel_err=0.
  - Round-robin pointer last=NUM_IN-1, so channel 0 has first priority.
- Load condition: can_load = !out_valid || out_ready.
- Channel choice (win):
  - MODE=0: win=sel, and win is legal only if sel<NUM_IN.
  - MODE=1: win is the first i with in_valid[i]=1, scanning from last+1 upward and wrapping NUM_IN-1 -> 0. There is no winner if no channel is valid.
- in_ready[i] = can_load && legal winner exists && (i==win). This holds in MODE=0 even when in_valid[sel]=0. At most one in_ready bit is high per cycle.
- Transfer on channel i occurs when in_valid[i] && in_ready[i]. At the next edge:
  - out_data = in_data[win]
  - grant = win
  - out_valid = 1
  - MODE=1 only: last = win.
- Latency is 1 cycle from input transfer to out_valid.
- Throughput is 1 beat/cycle with out_ready=1: drain and load happen on the same edge.
- Drain with no load (out_valid && out_ready, no input transfer): out_valid -> 0. out_data and grant hold their last values.
- Stall (out_valid && !out_ready): out_data, grant and out_valid hold stable, all in_ready=0, and last does not move.
- The round-robin pointer advances only on an accepted beat. A valid channel that is stalled keeps its priority.
- MODE=1 fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,...,NUM_IN-1,0,... and every channel is served within NUM_IN beats.
- Out-of-range sel (MODE=0, sel>=NUM_IN; only possible when NUM_IN is not a power of 2):
  - All in_ready=0 and nothing loads.
  - sel_err=1 on the next edge, independent of in_valid.
  - sel_err clears on the first edge after sel returns in range.
- sel may change on any cycle. The value sampled at the transfer edge decides which channel loads.
- MODE=1 ties the sel_err register to 0.
- in_valid may drop without a transfer, which is not a protocol error for this block. Upstream holds data stable while valid && !ready.
- No X is ever produced on out_data.

Test Plan:
- Reset with MODE=0, NUM_IN=4, sel=2, in_valid=4'b0100, in_data ch2=32'hDEAD_BEEF, out_ready=1, rst_n=0 for 2 cycles then 1 -> out_valid=0 and out_data=0 through reset. One cycle after release, out_valid=1, out_data=DEAD_BEEF, grant=2.
- Backpressure in MODE=0: load ch1=32'h1111, hold out_ready=0 for 3 cycles -> out_data stays 1111, in_ready=0000 for those cycles. Set out_ready=1 with ch1 presenting 2222 -> next cycle out_data=2222, no bubble.
- Round-robin with MODE=1, NUM_IN=4, all in_valid=1111, out_ready=1 for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3. Then in_valid=1010 -> grants alternate 1,3.
- Pointer hold in MODE=1: last grant=1, out_ready=0 for 2 cycles, in_valid=1111 -> no grant change. On release, next grant=2.
- Illegal select with MODE=0, NUM_IN=3, sel=3, in_valid=3'b111 -> in_ready=000, out_valid drops after drain, sel_err=1 the following cycle. sel=0 -> sel_err=0 next cycle and ch0 loads.
- Reset mid-operation: out_valid=1 stalled, assert rst_n=0 for one cycle -> out_valid=0 and grant=0. In MODE=1 the first post-reset grant goes to channel 0.
